// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the apb_uart register-port arbiter.
package uart_arb_pkg;

  localparam int UART_ADDR_W     = 12;
  localparam int UART_DATA_W     = 32;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_apb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Offset N_REQ lands back on last_i, so the previous winner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_i) + k) % N_REQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Round-robin APB master sharing the apb_uart register port among N_REQ requesters.
// Optional ACCESS-phase timeout is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_apb_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                              pclk_i,
  input  logic                              prst_i,
  input  logic [N_REQ-1:0]                  req_i,
  input  logic [N_REQ-1:0]                  req_write_i,
  input  logic [N_REQ-1:0][UART_ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ-1:0][UART_DATA_W-1:0] req_wdata_i,
  output logic [N_REQ-1:0]                  gnt_o,
  output logic [N_REQ-1:0]                  rsp_valid_o,
  output logic [UART_DATA_W-1:0]            rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              psel_o,
  output logic                              penable_o,
  output logic                              pwrite_o,
  output logic [UART_ADDR_W-1:0]            paddr_o,
  output logic [UART_DATA_W-1:0]            pwdata_o,
  input  logic [UART_DATA_W-1:0]            prdata_i,
  input  logic                              pready_i,
  input  logic                              pslverr_i
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("uart_apb_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          win_q, win_d, last_q, last_d, pick_idx;
  logic                   mask_q, mask_d;
  logic [UART_ADDR_W-1:0] addr_q, addr_d;
  logic [UART_DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                   write_q, write_d, err_q, err_d;
  logic [N_REQ-1:0]       last_oh, win_oh, elig, pick_oh;
  logic                   pick_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
    assign last_oh[gi] = (last_q == IW'(gi));
    assign win_oh[gi]  = (win_q == IW'(gi));
  end

  // Keep a requester that is still holding req_i from winning again straight after RESP.
  assign elig = req_i & ~({N_REQ{mask_q}} & last_oh);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i   (elig),
    .last_i  (last_q),
    .gnt_o   (pick_oh),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_idx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    mask_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          addr_d  = req_addr_i[pick_idx];
          wdata_d = req_wdata_i[pick_idx];
          write_d = req_write_i[pick_idx];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (pready_i) begin
          rdata_d = write_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = ST_RESP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ST_RESP: begin
        last_d  = win_q;
        mask_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      mask_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign pwrite_o    = psel_o & write_q;
  assign paddr_o     = psel_o ? addr_q : '0;
  assign pwdata_o    = psel_o ? wdata_q : '0;
  assign gnt_o       = (state_q != ST_IDLE) ? win_oh : '0;
  assign rsp_valid_o = (state_q == ST_RESP) ? win_oh : '0;
  assign rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == ST_RESP) & err_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Self-checking bench for uart_apb_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_uart_apb_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         req, req_write;
  logic [N-1:0][11:0]   req_addr;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0]         gnt, rsp_valid;
  logic [31:0]          rsp_rdata, pwdata, prdata;
  logic                 rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [11:0]          paddr;

  int checks = 0;
  int errors = 0;

  uart_apb_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .pclk_i      (clk),
    .prst_i      (rst),
    .req_i       (req),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req = '1;
    tick();
    tick();
    checks++;
    if ({gnt, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rsp_valid=%b rdata=%h err=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, expected all 0",
               gnt, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata);
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single_write();
    req[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 12'h004; req_wdata[0] = 32'h0000_00A5;
    pready = 1'b1;
    tick();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, gnt, rsp_valid} !== {1'b1, 1'b0, 1'b1, 12'h004, 32'hA5, 4'b0001, 4'b0000}) begin
      errors++;
      $display("FAIL write_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h gnt=%b rv=%b, expected 1 0 1 004 000000a5 0001 0000",
               psel, penable, pwrite, paddr, pwdata, gnt, rsp_valid);
    end
    tick();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, gnt, rsp_valid} !== {1'b1, 1'b1, 1'b1, 12'h004, 32'hA5, 4'b0001, 4'b0000}) begin
      errors++;
      $display("FAIL write_access: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h gnt=%b rv=%b, expected 1 1 1 004 000000a5 0001 0000",
               psel, penable, pwrite, paddr, pwdata, gnt, rsp_valid);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, paddr, gnt} !== {4'b0001, 1'b0, 32'h0, 1'b0, 12'h0, 4'b0001}) begin
      errors++;
      $display("FAIL write_resp: rv=%b err=%b rdata=%h psel=%b paddr=%h gnt=%b, expected 0001 0 00000000 0 000 0001",
               rsp_valid, rsp_err, rsp_rdata, psel, paddr, gnt);
    end
    req[0] = 1'b0;
    tick();
    checks++;
    if ({gnt, rsp_valid, psel} !== '0) begin
      errors++;
      $display("FAIL write_idle: gnt=%b rv=%b psel=%b, expected 0", gnt, rsp_valid, psel);
    end
  endtask

  task automatic test_two_reads();
    int t_g1 = -1;
    int t_g2 = -1;
    int n_rsp = 0;
    do_reset();
    req[1] = 1'b1; req_addr[1] = 12'h010;
    req[2] = 1'b1; req_addr[2] = 12'h020;
    prdata = 32'h11;
    for (int c = 1; c <= 30 && n_rsp < 2; c++) begin
      tick();
      if (gnt[1] && t_g1 < 0) t_g1 = c;
      if (gnt[2] && t_g2 < 0) t_g2 = c;
      if (rsp_valid != '0) begin
        checks++;
        if (n_rsp == 0 && {rsp_valid, rsp_rdata} !== {4'b0010, 32'h11}) begin
          errors++;
          $display("FAIL two_reads_first: rv=%b rdata=%h, expected 0010 00000011", rsp_valid, rsp_rdata);
        end
        if (n_rsp == 1 && {rsp_valid, rsp_rdata} !== {4'b0100, 32'h22}) begin
          errors++;
          $display("FAIL two_reads_second: rv=%b rdata=%h, expected 0100 00000022", rsp_valid, rsp_rdata);
        end
        if (rsp_valid[1]) begin req[1] = 1'b0; prdata = 32'h22; end
        if (rsp_valid[2]) req[2] = 1'b0;
        n_rsp++;
      end
    end
    checks++;
    if (n_rsp != 2 || t_g1 != 1 || t_g2 - t_g1 != 4) begin
      errors++;
      $display("FAIL two_reads_timing: responses=%0d gnt1_at=%0d gnt2_at=%0d, expected 2 1 5", n_rsp, t_g1, t_g2);
    end
    req = '0;
  endtask

  task automatic test_all_four();
    int order[$];
    int idx;
    do_reset();
    req = '1;
    for (int i = 0; i < N; i++) req_addr[i] = 12'(16 * i);
    for (int c = 1; c <= 40 && order.size() < 5; c++) begin
      tick();
      if (rsp_valid != '0) begin
        checks++;
        if (!$onehot(rsp_valid)) begin
          errors++;
          $display("FAIL all_four_onehot: rv=%b, expected one-hot", rsp_valid);
        end
        idx = -1;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) idx = i;
        order.push_back(idx);
      end
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL all_four_count: responses=%0d, expected 5", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != k % N) begin
        errors++;
        $display("FAIL all_four_order: grant %0d went to req %0d, expected %0d", k, order[k], k % N);
      end
    end
    req = '0;
  endtask

  task automatic test_mask();
    int setups[$];
    do_reset();
    req[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (psel && !penable && gnt[0]) setups.push_back(c);
    end
    checks++;
    if (setups.size() != 2 || setups[0] != 1 || setups[1] != 6) begin
      errors++;
      $display("FAIL mask_held_request: setups=%0d first=%0d second=%0d, expected 2 1 6",
               setups.size(), setups.size() > 0 ? setups[0] : -1, setups.size() > 1 ? setups[1] : -1);
    end
    req = '0;
  endtask

  task automatic test_wait_states();
    int acc = 0;
    do_reset();
    req[3] = 1'b1; req_addr[3] = 12'h0C8; prdata = 32'h5A5A; pready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (penable) begin
        acc++;
        pready = (acc >= 4);
      end
      if (psel) begin
        checks++;
        if (paddr !== 12'h0C8) begin
          errors++;
          $display("FAIL wait_paddr: cycle %0d paddr=%h, expected 0c8", c, paddr);
        end
      end
      checks++;
      if (c == 6) begin
        if ({rsp_valid, rsp_rdata} !== {4'b1000, 32'h5A5A}) begin
          errors++;
          $display("FAIL wait_resp: rv=%b rdata=%h, expected 1000 00005a5a", rsp_valid, rsp_rdata);
        end
        req[3] = 1'b0;
      end else if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL wait_stray_rsp: cycle %0d rv=%b, expected 0000", c, rsp_valid);
      end
    end
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL wait_access_cycles: got %0d, expected 4", acc);
    end
    pready = 1'b1;
  endtask

  task automatic test_slverr();
    req[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 12'h00C; req_wdata[2] = 32'hCAFE;
    pready = 1'b1; pslverr = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0100, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL slverr_resp: rv=%b err=%b rdata=%h, expected 0100 1 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    req[2] = 1'b0; pslverr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    req[1] = 1'b1; req_addr[1] = 12'h044; pready = 1'b0;
    tick();
    tick();
    checks++;
    if ({psel, penable, gnt} !== {1'b1, 1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL midreset_access: psel=%b penable=%b gnt=%b, expected 1 1 0010", psel, penable, gnt);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: gnt=%b rv=%b psel=%b penable=%b paddr=%h, expected all 0", gnt, rsp_valid, psel, penable, paddr);
    end
    rst = 1'b0; req[1] = 1'b0; pready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if ({rsp_valid, psel} !== '0) begin
        errors++;
        $display("FAIL midreset_abandoned: cycle %0d rv=%b psel=%b, expected 0", c, rsp_valid, psel);
      end
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int acc = 0;
    int got = -1;
    do_reset();
    req[0] = 1'b1; req_addr[0] = 12'h018; prdata = 32'hFFFF_FFFF; pready = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (penable) acc++;
      if (rsp_valid != '0 && got < 0) begin
        got = c;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL timeout_resp: rv=%b err=%b rdata=%h, expected 0001 1 00000000", rsp_valid, rsp_err, rsp_rdata);
        end
        req[0] = 1'b0;
      end
    end
    checks++;
    if (got != 10 || acc != TO) begin
      errors++;
      $display("FAIL timeout_timing: resp_at=%0d access_cycles=%0d, expected 10 %0d", got, acc, TO);
    end
    // pready arriving on the final allowed cycle must win over the timeout
    acc = 0;
    got = -1;
    req[0] = 1'b1; prdata = 32'h3C;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (penable) begin
        acc++;
        pready = (acc >= TO);
      end
      if (rsp_valid != '0 && got < 0) begin
        got = c;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b0, 32'h3C}) begin
          errors++;
          $display("FAIL timeout_pready_wins: rv=%b err=%b rdata=%h, expected 0001 0 0000003c", rsp_valid, rsp_err, rsp_rdata);
        end
        req[0] = 1'b0;
      end
    end
    checks++;
    if (got < 0) begin
      errors++;
      $display("FAIL timeout_pready_wins_missing: no response within 14 cycles, expected one");
    end
    pready = 1'b1;
  endtask
`endif

  task automatic test_random(input int ncyc);
    int stage, win, last_w, acc;
    int cool[N];
    bit mask, found;
    logic [N-1:0] elig, e_gnt, e_rv;
    logic [11:0]  l_addr;
    logic [31:0]  l_wdata, e_rdata;
    logic         l_write, e_err, e_psel, e_pen;
    do_reset();
    stage = 0; win = 0; last_w = N - 1; mask = 1'b0; acc = 0;
    l_addr = '0; l_wdata = '0; l_write = 1'b0; e_rdata = '0; e_err = 1'b0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      // Advance the reference model with the inputs that the edge just sampled.
      case (stage)
        0: begin
          elig = req;
          if (mask) elig[last_w] = 1'b0;
          mask = 1'b0;
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            if (!found && elig[(last_w + k) % N]) begin
              win = (last_w + k) % N;
              found = 1'b1;
            end
          end
          if (found) begin
            l_addr = req_addr[win]; l_wdata = req_wdata[win]; l_write = req_write[win];
            stage = 1;
          end
        end
        1: begin stage = 2; acc = 0; end
        2: begin
          if (pready) begin
            e_rdata = l_write ? 32'h0 : prdata;
            e_err = pslverr;
            stage = 3;
          end else begin
            acc++;
`ifdef UART_ARB_TIMEOUT_EN
            if (acc == TO) begin
              e_rdata = 32'h0;
              e_err = 1'b1;
              stage = 3;
            end
`endif
          end
        end
        default: begin last_w = win; mask = 1'b1; stage = 0; end
      endcase
      e_gnt = '0; e_rv = '0;
      if (stage != 0) e_gnt[win] = 1'b1;
      if (stage == 3) e_rv[win] = 1'b1;
      e_psel = (stage == 1 || stage == 2);
      e_pen = (stage == 2);
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL rnd_gnt: cycle %0d gnt=%b, expected %b", c, gnt, e_gnt);
      end
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata} !==
          {e_psel, e_pen, e_psel & l_write, e_psel ? l_addr : 12'h0, e_psel ? l_wdata : 32'h0}) begin
        errors++;
        $display("FAIL rnd_apb: cycle %0d psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h, expected %b %b %b %h %h",
                 c, psel, penable, pwrite, paddr, pwdata, e_psel, e_pen, e_psel & l_write,
                 e_psel ? l_addr : 12'h0, e_psel ? l_wdata : 32'h0);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {e_rv, (stage == 3) & e_err, (stage == 3) ? e_rdata : 32'h0}) begin
        errors++;
        $display("FAIL rnd_rsp: cycle %0d rv=%b err=%b rdata=%h, expected %b %b %h",
                 c, rsp_valid, rsp_err, rsp_rdata, e_rv, (stage == 3) & e_err, (stage == 3) ? e_rdata : 32'h0);
      end
      // Requester behaviour: hold until served, then either re-request at once or back off.
      for (int i = 0; i < N; i++) begin
        if (stage == 3 && win == i) begin
          if ($urandom_range(0, 2) == 0) begin
            req_addr[i] = 12'($urandom); req_wdata[i] = $urandom; req_write[i] = 1'($urandom);
          end else begin
            req[i] = 1'b0;
            cool[i] = $urandom_range(0, 3);
          end
        end else if (req[i]) begin
          if ((stage == 1 || stage == 2) && win == i && $urandom_range(0, 1) == 1) begin
            req_addr[i] = 12'($urandom); req_wdata[i] = $urandom; req_write[i] = 1'($urandom);
          end
        end else if (cool[i] > 0) begin
          cool[i]--;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_addr[i] = 12'($urandom); req_wdata[i] = $urandom; req_write[i] = 1'($urandom);
        end
      end
      pready = ($urandom_range(0, 3) != 0);
      prdata = $urandom;
      pslverr = ($urandom_range(0, 4) == 0);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_two_reads();
    test_all_four();
    test_mask();
    test_wait_states();
    test_slverr();
    test_reset_mid_access();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
